// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the two-port memory arbiter:
//   - state_t      : 2-bit FSM encoding IDLE/ACCESS/WAIT/DONE
//   - GNT_I/GNT_D  : grant identifiers (instruction side / data side)
//   - STARVE_LIMIT : consecutive D grants tolerated while I is waiting
//   - lat_load()   : latency-counter preload for a given RAM read latency
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam logic [1:0] STARVE_LIMIT = 2'd2;

  // Read latency is legal from 1 to 3, so the preload always fits in 2 bits.
  function automatic logic [1:0] lat_load(input int lat);
    return 2'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick
//   Winner selection between the instruction-side and data-side requesters,
//   together with the arbitration history register.
//   Configuration macro: MEM_ARB_RR_EN
//     undefined : fixed priority to D, with a 2-bit starvation counter that
//                 forces a grant to I after two consecutive D grants made
//                 while I was requesting.
//     defined   : round-robin using a last-grant flip-flop (reset favours D).
//   Ports:
//     g_clk    in   clock
//     g_clr    in   asynchronous active-low reset
//     i_req    in   instruction-side request
//     d_req    in   data-side request
//     grant_en in   a grant is being made this cycle (update history)
//     winner   out  GNT_I or GNT_D, combinational from the requests/history
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic g_clk,
  input  logic g_clr,
  input  logic i_req,
  input  logic d_req,
  input  logic grant_en,
  output logic winner
);

`ifdef MEM_ARB_RR_EN

  logic last_gnt_reg;

  always_comb begin
    winner = GNT_D;
    if (i_req && d_req) begin
      winner = (last_gnt_reg == GNT_D) ? GNT_I : GNT_D;
    end else if (i_req) begin
      winner = GNT_I;
    end
  end

  // Reset value GNT_I makes D the preferred side for the first contention.
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      last_gnt_reg <= GNT_I;
    end else if (grant_en) begin
      last_gnt_reg <= winner;
    end
  end

`else

  logic [1:0] starve_cnt_reg;

  always_comb begin
    winner = GNT_D;
    if (!d_req) begin
      winner = GNT_I;
    end else if (i_req && (starve_cnt_reg >= STARVE_LIMIT)) begin
      winner = GNT_I;
    end
  end

  // Only an unbroken run of D grants with I waiting counts; a D grant with
  // I idle breaks the run. The counter never passes STARVE_LIMIT because at
  // that value the next grant either goes to I or sees I idle.
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      starve_cnt_reg <= 2'd0;
    end else if (grant_en) begin
      if (winner == GNT_I) begin
        starve_cnt_reg <= 2'd0;
      end else if (i_req) begin
        starve_cnt_reg <= starve_cnt_reg + 2'd1;
      end else begin
        starve_cnt_reg <= 2'd0;
      end
    end
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port RAM between an instruction-side reader and a
//   data-side reader/writer. One transaction at a time: IDLE grants and
//   latches the request, ACCESS issues a single RAM strobe, WAIT counts out
//   the RAM read latency and captures the data, DONE pulses the winner's odv.
//   Configuration macro: MEM_ARB_RR_EN (round-robin instead of fixed
//   priority with starvation guard; see arb_pick).
//   Parameters: d_width (data), a_width (address), rd_lat (1..3 RAM read
//   latency, counted from the ram_cs edge to valid ram_rdata).
//   Ports:
//     g_clk, g_clr                    clock, async active-low reset
//     i_req, i_addr                   I-side read request (held until i_odv)
//     i_rdata, i_odv                  I-side read data, one-cycle done pulse
//     d_req, d_we, d_addr, d_wdata    D-side request (held until d_odv)
//     d_rdata, d_odv                  D-side read data, one-cycle done pulse
//     ram_cs, ram_we, ram_addr,
//     ram_wdata, ram_rdata            shared RAM port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int d_width = 8,
  parameter int a_width = 8,
  parameter int rd_lat  = 1
) (
  input  logic               g_clk,
  input  logic               g_clr,
  input  logic               i_req,
  input  logic [a_width-1:0] i_addr,
  output logic [d_width-1:0] i_rdata,
  output logic               i_odv,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [a_width-1:0] d_addr,
  input  logic [d_width-1:0] d_wdata,
  output logic [d_width-1:0] d_rdata,
  output logic               d_odv,
  output logic               ram_cs,
  output logic               ram_we,
  output logic [a_width-1:0] ram_addr,
  output logic [d_width-1:0] ram_wdata,
  input  logic [d_width-1:0] ram_rdata
);

  localparam logic [1:0] LAT_LOAD = lat_load(rd_lat);

  state_t               state_reg, state_next;
  logic                 gnt_reg, gnt_next;
  logic [a_width-1:0]   addr_reg, addr_next;
  logic                 we_reg, we_next;
  logic [d_width-1:0]   wdata_reg, wdata_next;
  logic [1:0]           lat_cnt_reg, lat_cnt_next;
  logic [d_width-1:0]   i_rdata_reg, i_rdata_next;
  logic [d_width-1:0]   d_rdata_reg, d_rdata_next;
  logic                 grant_en;
  logic                 winner;

  arb_pick u_arb_pick (
    .g_clk    (g_clk),
    .g_clr    (g_clr),
    .i_req    (i_req),
    .d_req    (d_req),
    .grant_en (grant_en),
    .winner   (winner)
  );

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state_reg   <= IDLE;
      gnt_reg     <= GNT_I;
      addr_reg    <= '0;
      we_reg      <= 1'b0;
      wdata_reg   <= '0;
      lat_cnt_reg <= 2'd0;
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      addr_reg    <= addr_next;
      we_reg      <= we_next;
      wdata_reg   <= wdata_next;
      lat_cnt_reg <= lat_cnt_next;
      i_rdata_reg <= i_rdata_next;
      d_rdata_reg <= d_rdata_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    addr_next    = addr_reg;
    we_next      = we_reg;
    wdata_next   = wdata_reg;
    lat_cnt_next = lat_cnt_reg;
    i_rdata_next = i_rdata_reg;
    d_rdata_next = d_rdata_reg;
    grant_en     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          grant_en = 1'b1;
          gnt_next = winner;
          if (winner == GNT_D) begin
            addr_next  = d_addr;
            we_next    = d_we;
            wdata_next = d_wdata;
          end else begin
            // The I side is read-only.
            addr_next  = i_addr;
            we_next    = 1'b0;
            wdata_next = '0;
          end
          state_next = ACCESS;
        end
      end

      ACCESS: begin
        if (we_reg) begin
          state_next = DONE;
        end else begin
          // Every read spends at least one WAIT cycle: the RAM data becomes
          // valid rd_lat edges after the strobe, and the capture happens on
          // the edge that leaves WAIT with the counter at zero.
          lat_cnt_next = LAT_LOAD;
          state_next   = WAIT;
        end
      end

      WAIT: begin
        if (lat_cnt_reg == 2'd0) begin
          if (gnt_reg == GNT_D) begin
            d_rdata_next = ram_rdata;
          end else begin
            i_rdata_next = ram_rdata;
          end
          state_next = DONE;
        end else begin
          lat_cnt_next = lat_cnt_reg - 2'd1;
        end
      end

      DONE: begin
        // No grant here: requesters see odv this cycle and may still hold req.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ram_cs    = (state_reg == ACCESS);
  assign ram_we    = ram_cs && we_reg;
  assign ram_addr  = addr_reg;
  assign ram_wdata = wdata_reg;

  assign i_odv   = (state_reg == DONE) && (gnt_reg == GNT_I);
  assign d_odv   = (state_reg == DONE) && (gnt_reg == GNT_D);
  assign i_rdata = i_rdata_reg;
  assign d_rdata = d_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk;
  logic clr;

  // Instance with rd_lat = 1
  logic       i_req, d_req, d_we;
  logic [7:0] i_addr, d_addr, d_wdata;
  logic [7:0] i_rdata, d_rdata;
  logic       i_odv, d_odv;
  logic       ram_cs, ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  // Instance with rd_lat = 3
  logic       b_i_req, b_d_req, b_d_we;
  logic [7:0] b_i_addr, b_d_addr, b_d_wdata;
  logic [7:0] b_i_rdata, b_d_rdata;
  logic       b_i_odv, b_d_odv;
  logic       b_ram_cs, b_ram_we;
  logic [7:0] b_ram_addr, b_ram_wdata, b_ram_rdata;

  logic       dut_sel;
  logic       m_cs, m_we, m_i_odv, m_d_odv;
  logic [7:0] m_addr;

  int pass_cnt;
  int total_cnt;

  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] s1, s2;

  mem_arbiter #(.d_width(8), .a_width(8), .rd_lat(1)) dut1 (
    .g_clk(clk), .g_clr(clr),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_odv(i_odv),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_odv(d_odv),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  mem_arbiter #(.d_width(8), .a_width(8), .rd_lat(3)) dut3 (
    .g_clk(clk), .g_clr(clr),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_odv(b_i_odv),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_odv(b_d_odv),
    .ram_cs(b_ram_cs), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  assign m_cs    = dut_sel ? b_ram_cs   : ram_cs;
  assign m_we    = dut_sel ? b_ram_we   : ram_we;
  assign m_addr  = dut_sel ? b_ram_addr : ram_addr;
  assign m_i_odv = dut_sel ? b_i_odv    : i_odv;
  assign m_d_odv = dut_sel ? b_d_odv    : d_odv;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM models; contents reload to addr ^ 0x2C while reset is low.
  always @(posedge clk) begin
    if (!clr) begin
      for (int a = 0; a < 256; a++) mem1[a] <= 8'(a) ^ 8'h2C;
      ram_rdata <= 8'h00;
    end else begin
      ram_rdata <= 8'hEE;
      if (ram_cs && ram_we) mem1[ram_addr] <= ram_wdata;
      else if (ram_cs) ram_rdata <= mem1[ram_addr];
    end
  end

  always @(posedge clk) begin
    if (!clr) begin
      for (int a = 0; a < 256; a++) mem3[a] <= 8'(a) ^ 8'h2C;
      s1 <= 8'h00;
      s2 <= 8'h00;
      b_ram_rdata <= 8'h00;
    end else begin
      s1 <= (b_ram_cs && !b_ram_we) ? mem3[b_ram_addr] : 8'hEE;
      s2 <= s1;
      b_ram_rdata <= s2;
      if (b_ram_cs && b_ram_we) mem3[b_ram_addr] <= b_ram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic side_d, input logic we, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic req);
    if (dut_sel) begin
      if (side_d) begin
        b_d_req = req; b_d_we = we; b_d_addr = addr; b_d_wdata = wdata;
      end else begin
        b_i_req = req; b_i_addr = addr;
      end
    end else begin
      if (side_d) begin
        d_req = req; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
        i_req = req; i_addr = addr;
      end
    end
  endtask

  // One transaction, started at a negedge. Request is held one cycle past
  // the odv pulse so that a grant in DONE would show up as a second strobe.
  task automatic do_txn(input logic side_d, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, input int exp_lat, input string tag);
    int n, cs_cnt, first_cs;
    logic seen, other, cs_we;
    logic [7:0] cs_addr;
    n = 0; cs_cnt = 0; first_cs = 0; seen = 1'b0; other = 1'b0;
    cs_we = 1'b0; cs_addr = 8'h00;
    drive(side_d, we, addr, wdata, 1'b1);
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (m_cs) begin
        cs_cnt++;
        if (cs_cnt == 1) begin
          first_cs = n; cs_addr = m_addr; cs_we = m_we;
        end
      end
      if (side_d ? m_d_odv : m_i_odv) begin
        seen = 1'b1;
        other = side_d ? m_i_odv : m_d_odv;
      end
    end
    @(negedge clk);
    if (m_cs) cs_cnt++;
    drive(side_d, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    if (m_cs) cs_cnt++;
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_other_odv"}, {31'd0, other}, 32'd0);
    chk({tag, "_cs_count"}, cs_cnt, 1);
    chk({tag, "_cs_cycle"}, first_cs, 1);
    chk({tag, "_ram_addr"}, {24'd0, cs_addr}, {24'd0, addr});
    chk({tag, "_ram_we"}, {31'd0, cs_we}, {31'd0, side_d & we});
  endtask

  initial begin
    int n, ng, both, odv_cnt;
    logic [5:0] order;
    logic [5:0] exp_order;

    pass_cnt = 0; total_cnt = 0;
    clr = 1'b0; dut_sel = 1'b0;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    b_i_req = 0; b_i_addr = 0; b_d_req = 0; b_d_we = 0; b_d_addr = 0; b_d_wdata = 0;
    order = 6'd0;
`ifdef MEM_ARB_RR_EN
    exp_order = 6'b010101;   // bit 0 first: D,I,D,I,D,I (1 = D)
`else
    exp_order = 6'b011011;   // bit 0 first: D,D,I,D,D,I
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_i_odv", {31'd0, i_odv}, 32'd0);
    chk("rst_d_odv", {31'd0, d_odv}, 32'd0);
    chk("rst_ram_cs", {31'd0, ram_cs}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
    chk("rst_i_rdata", {24'd0, i_rdata}, 32'd0);
    chk("rst_d_rdata", {24'd0, d_rdata}, 32'd0);
    chk("rst_b_ram_cs", {31'd0, b_ram_cs}, 32'd0);
    chk("rst_b_i_rdata", {24'd0, b_i_rdata}, 32'd0);
    chk("rst_b_d_rdata", {24'd0, b_d_rdata}, 32'd0);
    clr = 1'b1;
    @(negedge clk);

    // Both sides requesting continuously: grant order
    i_req = 1; i_addr = 8'h44; d_req = 1; d_we = 1; d_addr = 8'h30; d_wdata = 8'h77;
    ng = 0; both = 0; n = 0;
    while (ng < 6 && n < 100) begin
      @(negedge clk);
      n++;
      if (i_odv && d_odv) both++;
      if (i_odv || d_odv) begin
        order[ng] = d_odv;
        ng++;
      end
    end
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    @(negedge clk);
    chk("arb_grants", ng, 6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("arb_order%0d", k), {31'd0, order[k]}, {31'd0, exp_order[k]});
    chk("arb_overlap", both, 0);
    chk("arb_i_rdata", {24'd0, i_rdata}, 32'h68);

    // I read of 0x10 (RAM holds 0x3C)
    do_txn(1'b0, 1'b0, 8'h10, 8'h00, 3, "i_rd10");
    chk("i_rd10_data", {24'd0, i_rdata}, 32'h3C);

    // D write 0x20 <- 0xA5, then read it back
    do_txn(1'b1, 1'b1, 8'h20, 8'hA5, 2, "d_wr20");
    chk("d_wr20_rdata_hold", {24'd0, d_rdata}, 32'h00);
    do_txn(1'b1, 1'b0, 8'h20, 8'h00, 3, "d_rd20");
    chk("d_rd20_data", {24'd0, d_rdata}, 32'hA5);
    chk("i_rdata_hold", {24'd0, i_rdata}, 32'h3C);

    // D read whose request drops right after the grant still completes
    d_req = 1; d_we = 0; d_addr = 8'h11;
    @(negedge clk);
    n = 1;
    d_req = 0; d_addr = 0;
    while (!d_odv && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drop_lat", n, 3);
    chk("drop_data", {24'd0, d_rdata}, 32'h3D);
    @(negedge clk);

    // rd_lat = 3 instance: read of 0x05 (RAM holds 0x29)
    dut_sel = 1'b1;
    do_txn(1'b0, 1'b0, 8'h05, 8'h00, 5, "lat3_rd05");
    chk("lat3_rd05_data", {24'd0, b_i_rdata}, 32'h29);
    dut_sel = 1'b0;

    // Reset asserted while a read is in WAIT
    i_req = 1; i_addr = 8'h10;
    @(negedge clk);
    chk("rstw_access_cs", {31'd0, ram_cs}, 32'd1);
    @(negedge clk);
    clr = 1'b0;
    i_req = 0; i_addr = 0;
    #1;
    chk("rstw_i_odv", {31'd0, i_odv}, 32'd0);
    chk("rstw_ram_cs", {31'd0, ram_cs}, 32'd0);
    chk("rstw_ram_addr", {24'd0, ram_addr}, 32'd0);
    chk("rstw_i_rdata", {24'd0, i_rdata}, 32'd0);
    chk("rstw_d_rdata", {24'd0, d_rdata}, 32'd0);
    odv_cnt = 0;
    @(negedge clk);
    if (i_odv || d_odv) odv_cnt++;
    clr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (i_odv || d_odv) odv_cnt++;
    end
    chk("rstw_no_odv", odv_cnt, 0);
    do_txn(1'b0, 1'b0, 8'h10, 8'h00, 3, "post_rst");
    chk("post_rst_data", {24'd0, i_rdata}, 32'h3C);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
